softmax_norm: RTL

Normalisation stage directly downstream of the Q6.10 adder tree. It takes the tree's reduced sum and the element vector delayed alongside it, and computes one reciprocal of the sum with a sequential restoring divider. It then scales every element by that reciprocal in one parallel multiply step. The block closes the softmax datapath: a vector of exponentials in, a vector of normalised probabilities out.

---
 rtl/softmax_norm_pkg.sv | 28 ++
 rtl/softmax_norm_recip_div_fx16.sv | 86 ++++++++
 rtl/softmax_norm.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/softmax_norm_pkg.sv
// santa_norm_pkg: shared constants, FSM state type and saturation helper for
// the softmax normalisation stage (softmax_norm) and its reciprocal divider.
//   DATA_W    : Q6.10 element / sum width
//   FRAC_W    : fractional bits of the Q6.10 format
//   DIV_ITER  : restoring-division iterations (21-bit quotient)
//   RECIP_ONE : dividend 2^20, so quotient = 1.0/sum in Q6.10
package santa_norm_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAC_W    = 10;
  localparam int unsigned DIV_ITER  = 21;
  localparam int unsigned RECIP_ONE = 1 << 20;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    MUL,
    DONE
  } state_e;

  // Clamp a signed 32-bit value into the signed 16-bit range.
  function automatic logic [DATA_W-1:0] sat16(input logic signed [31:0] x);
    if (x > 32'sh0000_7FFF)      return 16'h7FFF;
    else if (x < 32'shFFFF_8000) return 16'h8000;
    else                         return x[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/softmax_norm_recip_div_fx16.sv
// recip_div_fx16: sequential restoring divider computing 2^20 / divisor,
// one quotient bit per enabled cycle, MSB first.
// Ports:
//   clk, rst, en : shared clock, synchronous active-high reset, clock-enable
//   start        : load dividend 2^20 and divisor on an enabled edge
//   divisor      : unsigned 16-bit divisor
//   busy         : iterations in progress
//   done         : high during the final iteration (its edge completes the quotient)
//   quotient     : 21-bit quotient, valid once busy has dropped
module recip_div_fx16
  import santa_norm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic [DATA_W-1:0]   divisor,
  output logic                busy,
  output logic                done,
  output logic [DIV_ITER-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DIV_ITER);

  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q,  cnt_d;
  logic [DATA_W-1:0]   rem_q,  rem_d;
  logic [DATA_W-1:0]   dvs_q,  dvs_d;
  logic [DIV_ITER-1:0] quo_q,  quo_d;
  logic [DATA_W:0]     rem_sh;

  // The quotient register doubles as the dividend shift register: each
  // iteration shifts a dividend bit out of the top into the remainder and a
  // quotient bit in at the bottom.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    rem_sh = {rem_q, quo_q[DIV_ITER-1]};
    if (en) begin
      if (start) begin
        busy_d = 1'b1;
        cnt_d  = CNT_W'(DIV_ITER - 1);
        rem_d  = '0;
        dvs_d  = divisor;
        quo_d  = DIV_ITER'(RECIP_ONE);
      end else if (busy_q) begin
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d = DATA_W'(rem_sh - {1'b0, dvs_q});
          quo_d = {quo_q[DIV_ITER-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[DATA_W-1:0];
          quo_d = {quo_q[DIV_ITER-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == '0);
  assign quotient = quo_q;

endmodule

// File: rtl/softmax_norm.sv
// softmax_norm: normalisation stage after the Q6.10 adder tree. Computes one
// reciprocal of the reduced sum with a sequential divider, then scales all N
// elements by it in a single parallel multiply step.
// Ports:
//   clk, rst, en  : clock, synchronous active-high reset, global clock-enable
//   valid_in      : sum_in / data_in_flat presented
//   in_ready      : combinational, high only in IDLE
//   sum_in        : signed Q6.10 sum
//   data_in_flat  : N signed Q6.10 elements, element i at [i*16 +: 16]
//   out_ready     : downstream accepts the output
//   valid_out     : registered output-valid
//   out_flat      : N normalised signed Q6.10 elements, same packing
// Build option: define SOFTMAX_NORM_SAT_EN to saturate the reciprocal and the
// products; otherwise both wrap (two's complement). A non-positive sum forces
// the reciprocal to 0x7FFF in either build.
module softmax_norm
  import santa_norm_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                valid_in,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   sum_in,
  input  logic [N*DATA_W-1:0] data_in_flat,
  input  logic                out_ready,
  output logic                valid_out,
  output logic [N*DATA_W-1:0] out_flat
);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     sum_q,   sum_d;
  logic [N*DATA_W-1:0]   data_q,  data_d;
  logic                  valid_q, valid_d;
  logic [N*DATA_W-1:0]   out_q,   out_d;

  logic                  div_start;
  logic                  div_busy_unused;
  logic                  div_done;
  logic [DIV_ITER-1:0]   quot;

  logic signed [DATA_W-1:0] recip;
  logic signed [31:0]       shf [N];
  logic [N*DATA_W-1:0]      mul_flat;

  recip_div_fx16 u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (div_start),
    .divisor  (sum_in),
    .busy     (div_busy_unused),
    .done     (div_done),
    .quotient (quot)
  );

  // Reciprocal of the captured sum; the divider runs its full length even for
  // a non-positive sum so latency stays constant, and the result is overridden.
  always_comb begin
    if (sum_q[DATA_W-1] || (sum_q == '0)) begin
      recip = 16'sh7FFF;
`ifdef SOFTMAX_NORM_SAT_EN
    end else if (quot > DIV_ITER'(16'h7FFF)) begin
      recip = 16'sh7FFF;
`endif
    end else begin
      recip = signed'(quot[DATA_W-1:0]);
    end
  end

  always_comb begin
    mul_flat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      shf[i] = (32'(signed'(data_q[i*DATA_W +: DATA_W])) * 32'(recip)) >>> FRAC_W;
`ifdef SOFTMAX_NORM_SAT_EN
      mul_flat[i*DATA_W +: DATA_W] = sat16(shf[i]);
`else
      mul_flat[i*DATA_W +: DATA_W] = shf[i][DATA_W-1:0];
`endif
    end
  end

`ifndef SOFTMAX_NORM_SAT_EN
  // Bits discarded by the wrapping narrowings.
  logic unused_hi;
  always_comb begin
    unused_hi = ^quot[DIV_ITER-1:DATA_W];
    for (int unsigned i = 0; i < N; i++) begin
      unused_hi = unused_hi ^ (^shf[i][31:DATA_W]);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    data_d    = data_q;
    valid_d   = valid_q;
    out_d     = out_q;
    div_start = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            sum_d     = sum_in;
            data_d    = data_in_flat;
            div_start = 1'b1;
            state_d   = DIV;
          end
        end
        DIV: begin
          if (div_done) state_d = MUL;
        end
        MUL: begin
          out_d   = mul_flat;
          valid_d = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          if (out_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign valid_out = valid_q;
  assign out_flat  = out_q;

endmodule
